// File: rtl/perspective_transformer_pkg.sv
// Shared types and constants for the perspective transformer.
//   PT_COORD_W  : width of one packed grid coordinate (u or v)
//   PT_GRID_MAX : last valid cell index of the tracked square grid
//   pt_point_t  : packed {u, v} result as presented on o_point
package pt_pkg;

   localparam int PT_COORD_W  = 7;
   localparam int PT_GRID_MAX = 63;

   typedef struct packed {
      logic signed [PT_COORD_W-1:0] u;
      logic signed [PT_COORD_W-1:0] v;
   } pt_point_t;

endpackage

// File: rtl/perspective_transformer_if.sv
// Request/result bundle between the coefficient solver and the overlay path.
//   i_start        request strobe, samples i_pixel and coefficients
//   i_pixel        {x[19:10], y[9:0]} unsigned screen pixel
//   i_A..i_H       signed Q(INT_W).(FRAC_W) homography coefficients
//   o_inside       mapped point lies on the 64x64 grid
//   o_point        {u, v} 7-bit two's-complement grid coordinates
//   o_valid        one-cycle pulse when o_point/o_inside update
// master drives requests; slave is the transformer.
interface perspective_transformer_if #(
   parameter int INT_W  = 20,
   parameter int FRAC_W = 13
);
   localparam int CW = INT_W + FRAC_W;

   logic                 i_start;
   logic [19:0]          i_pixel;
   logic signed [CW-1:0] i_A, i_B, i_C, i_D, i_E, i_F, i_G, i_H;
   logic                 o_inside;
   logic [13:0]          o_point;
   logic                 o_valid;

   modport master (
      output i_start, i_pixel, i_A, i_B, i_C, i_D, i_E, i_F, i_G, i_H,
      input  o_inside, o_point, o_valid
   );

   modport slave (
      input  i_start, i_pixel, i_A, i_B, i_C, i_D, i_E, i_F, i_G, i_H,
      output o_inside, o_point, o_valid
   );

endinterface

// File: rtl/perspective_transformer_floor_div.sv
// pt_floor_div: combinational signed divider rounding toward minus infinity.
//   num, den    signed dividend / divisor
//   quot        floor(num/den); forced to 0 when den <= 0
//   den_nonpos  den <= 0 (degenerate or behind-camera projection)
module pt_floor_div #(
   parameter int WIDTH = 45
) (
   input  logic signed [WIDTH-1:0] num,
   input  logic signed [WIDTH-1:0] den,
   output logic signed [WIDTH-1:0] quot,
   output logic                    den_nonpos
);

   logic signed [WIDTH-1:0] den_safe;
   logic signed [WIDTH-1:0] q_trunc;
   logic signed [WIDTH-1:0] r_trunc;

   assign den_nonpos = den[WIDTH-1] || (den == '0);
   // Substitute 1 so the divider never sees zero; result is discarded anyway.
   assign den_safe   = den_nonpos ? WIDTH'(1) : den;
   assign q_trunc    = num / den_safe;
   assign r_trunc    = num % den_safe;

   // Truncating divide rounds toward zero; step down when the exact result is negative.
   always_comb begin
      quot = q_trunc;
      if (den_nonpos)
         quot = '0;
      else if ((r_trunc != '0) && (r_trunc[WIDTH-1] != den_safe[WIDTH-1]))
         quot = q_trunc - WIDTH'(1);
   end

endmodule

// File: rtl/perspective_transformer.sv
// Pipelined homography mapper: screen pixel -> 7-bit grid coordinates.
//   i_clk, i_rst  clock and synchronous active-high reset
//   bus (slave)   request/result bundle, see perspective_transformer_if
// Pipeline: edge k stage-1 numerators/denominator, edge k+1 floor quotients,
// edge k+2 packed o_point/o_inside/o_valid. A new request may enter every cycle.
// Build option PT_SATURATE_EN: out-of-range u/v clamp to [-64,63] instead of
// wrapping to their low 7 bits. o_inside is the same in both builds.
module perspective_transformer
   import pt_pkg::*;
#(
   parameter int INT_W  = 20,
   parameter int FRAC_W = 13
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   perspective_transformer_if.slave bus
);

   localparam int CW = INT_W + FRAC_W;
   localparam int PW = CW + 12;
   localparam logic signed [PW-1:0] W_ONE    = PW'(1) <<< FRAC_W;
   localparam logic signed [PW-1:0] GRID_MAX = PW'(PT_GRID_MAX);
`ifdef PT_SATURATE_EN
   localparam logic signed [PW-1:0] COORD_LO = -PW'(2 ** (PT_COORD_W - 1));
`endif

   function automatic logic signed [PW-1:0] sx(input logic signed [CW-1:0] c);
      return {{(PW-CW){c[CW-1]}}, c};
   endfunction

   function automatic logic [PT_COORD_W-1:0] pack_coord(input logic signed [PW-1:0] q);
`ifdef PT_SATURATE_EN
      if (q > GRID_MAX)
         return GRID_MAX[PT_COORD_W-1:0];
      else if (q < COORD_LO)
         return COORD_LO[PT_COORD_W-1:0];
      else
         return q[PT_COORD_W-1:0];
`else
      return q[PT_COORD_W-1:0];
`endif
   endfunction

   logic signed [PW-1:0] x_s, y_s;
   logic signed [PW-1:0] xn_d, yn_d, w_d;
   logic signed [PW-1:0] xn_q, yn_q, w_q;
   logic                 s1_valid;
   logic signed [PW-1:0] u_d, v_d, u_q, v_q;
   logic                 nonpos_u, nonpos_v, w_nonpos_q;
   logic                 s2_valid;
   logic                 u_in, v_in;
   pt_point_t            point_d;

   assign x_s  = {{(PW-10){1'b0}}, bus.i_pixel[19:10]};
   assign y_s  = {{(PW-10){1'b0}}, bus.i_pixel[9:0]};
   assign xn_d = sx(bus.i_A) * x_s + sx(bus.i_B) * y_s + sx(bus.i_C);
   assign yn_d = sx(bus.i_D) * x_s + sx(bus.i_E) * y_s + sx(bus.i_F);
   assign w_d  = sx(bus.i_G) * x_s + sx(bus.i_H) * y_s + W_ONE;

   always_ff @(posedge i_clk) begin
      if (i_rst) s1_valid <= 1'b0;
      else       s1_valid <= bus.i_start;
      if (bus.i_start) begin
         xn_q <= xn_d;
         yn_q <= yn_d;
         w_q  <= w_d;
      end
   end

   pt_floor_div #(.WIDTH(PW)) u_div_u (
      .num(xn_q), .den(w_q), .quot(u_d), .den_nonpos(nonpos_u)
   );

   pt_floor_div #(.WIDTH(PW)) u_div_v (
      .num(yn_q), .den(w_q), .quot(v_d), .den_nonpos(nonpos_v)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) s2_valid <= 1'b0;
      else       s2_valid <= s1_valid;
      if (s1_valid) begin
         u_q        <= u_d;
         v_q        <= v_d;
         w_nonpos_q <= nonpos_u | nonpos_v;
      end
   end

   assign u_in = !u_q[PW-1] && (u_q <= GRID_MAX);
   assign v_in = !v_q[PW-1] && (v_q <= GRID_MAX);

   always_comb begin
      point_d.u = pack_coord(u_q);
      point_d.v = pack_coord(v_q);
      if (w_nonpos_q) point_d = '0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         bus.o_point  <= '0;
         bus.o_inside <= 1'b0;
         bus.o_valid  <= 1'b0;
      end else begin
         bus.o_valid <= s2_valid;
         if (s2_valid) begin
            bus.o_point  <= point_d;
            bus.o_inside <= !w_nonpos_q && u_in && v_in;
         end
      end
   end

endmodule

// File: tb/tb_perspective_transformer.sv
// Directed bench for perspective_transformer with hand-computed expectations.
module tb_perspective_transformer;

   localparam int CW = 33;

   logic i_clk = 1'b0;
   logic i_rst;
   always #5 i_clk = ~i_clk;

   perspective_transformer_if bus ();
   perspective_transformer dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pt(input int u, input int v);
      logic [6:0] uu, vv;
      uu = 7'(u);
      vv = 7'(v);
      return {18'd0, uu, vv};
   endfunction

   task automatic set_coef(input int a, b, c, d, e, f, g, h);
      bus.i_A = CW'(a); bus.i_B = CW'(b); bus.i_C = CW'(c); bus.i_D = CW'(d);
      bus.i_E = CW'(e); bus.i_F = CW'(f); bus.i_G = CW'(g); bus.i_H = CW'(h);
   endtask

   task automatic set_ident();
      set_coef(8192, 0, 0, 0, 8192, 0, 0, 0);
   endtask

   // One request; result must appear exactly two edges after the sampling edge.
   task automatic run_one(input string tag, input int x, input int y,
                          input logic [31:0] exp_pt, input logic exp_in);
      int lat;
      lat = -1;
      @(negedge i_clk);
      bus.i_pixel = {10'(x), 10'(y)};
      bus.i_start = 1'b1;
      for (int c = 1; c <= 8 && lat < 0; c++) begin
         @(negedge i_clk);
         bus.i_start = 1'b0;
         if (bus.o_valid) lat = c - 1;
      end
      check({tag, " latency"}, 32'(lat), 32'd2);
      check({tag, " point"},   32'(bus.o_point), exp_pt);
      check({tag, " inside"},  32'(bus.o_inside), 32'(exp_in));
   endtask

   logic [31:0] seen_pt [3];
   logic        seen_in [3];
   int          seen_c  [3];
   int          n_seen;

   initial begin
      i_rst = 1'b1;
      bus.i_start = 1'b0;
      bus.i_pixel = '0;
      set_coef(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge i_clk);
      check("reset valid",  32'(bus.o_valid),  32'd0);
      check("reset point",  32'(bus.o_point),  32'd0);
      check("reset inside", 32'(bus.o_inside), 32'd0);
      i_rst = 1'b0;

      // Xn=339927, Yn=510000, W=2*300+1*300+8192=9092 -> u=37, v=56
      set_coef(1269, -49, -26073, 152, 1974, -127800, 2, 1);
      run_one("homography", 300, 300, pt(37, 56), 1'b1);

      @(negedge i_clk);
      check("hold valid", 32'(bus.o_valid), 32'd0);
      check("hold point", 32'(bus.o_point), pt(37, 56));

      set_ident();
      run_one("ident 10,20", 10, 20, pt(10, 20), 1'b1);
      run_one("ident 63,63", 63, 63, pt(63, 63), 1'b1);
`ifdef PT_SATURATE_EN
      run_one("ident 100,5", 100, 5, pt(63, 5), 1'b0);
      run_one("ident 0,64", 0, 64, pt(0, 63), 1'b0);
`else
      run_one("ident 100,5", 100, 5, pt(-28, 5), 1'b0);
      run_one("ident 0,64", 0, 64, pt(0, -64), 1'b0);
`endif

      // -4096/8192 = -0.5 -> floor -1
      set_coef(8192, 0, -4096, 0, 8192, 0, 0, 0);
      run_one("floor", 0, 0, pt(-1, 0), 1'b0);

      set_coef(8192, 0, 0, 0, 8192, 0, -8192, 0);
      run_one("w zero", 1, 0, 32'd0, 1'b0);
      set_coef(8192, 0, 0, 0, 8192, 0, -16384, 0);
      run_one("w neg", 1, 0, 32'd0, 1'b0);

      // Back-to-back requests
      set_ident();
      n_seen = 0;
      @(negedge i_clk);
      bus.i_pixel = {10'd10, 10'd20};
      bus.i_start = 1'b1;
      @(negedge i_clk);
      bus.i_pixel = {10'd1, 10'd2};
      @(negedge i_clk);
      bus.i_pixel = {10'd64, 10'd3};
      for (int c = 0; c < 10; c++) begin
         @(negedge i_clk);
         bus.i_start = 1'b0;
         if (bus.o_valid && n_seen < 3) begin
            seen_pt[n_seen] = 32'(bus.o_point);
            seen_in[n_seen] = bus.o_inside;
            seen_c[n_seen]  = c;
            n_seen++;
         end
      end
      check("burst count", 32'(n_seen), 32'd3);
      if (n_seen == 3) begin
         check("burst first cycle", 32'(seen_c[0]), 32'd0);
         check("burst last cycle",  32'(seen_c[2]), 32'd2);
         check("burst pt0", seen_pt[0], pt(10, 20));
         check("burst pt1", seen_pt[1], pt(1, 2));
`ifdef PT_SATURATE_EN
         check("burst pt2", seen_pt[2], pt(63, 3));
`else
         check("burst pt2", seen_pt[2], pt(-64, 3));
`endif
         check("burst in0", 32'(seen_in[0]), 32'd1);
         check("burst in2", 32'(seen_in[2]), 32'd0);
      end

      // Reset one cycle after a start, with a competing start in the reset cycle
      n_seen = 0;
      @(negedge i_clk);
      bus.i_pixel = {10'd5, 10'd6};
      bus.i_start = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      bus.i_start = 1'b0;
      if (bus.o_valid) n_seen++;
      for (int c = 0; c < 5; c++) begin
         @(negedge i_clk);
         if (bus.o_valid) n_seen++;
      end
      check("reset flush valids", 32'(n_seen), 32'd0);
      check("reset flush point",  32'(bus.o_point), 32'd0);
      check("reset flush inside", 32'(bus.o_inside), 32'd0);

      set_ident();
      run_one("after reset", 7, 9, pt(7, 9), 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
